// File: rtl/serial_pad_scanner.sv
// serial_pad_scanner
// Drives one shared latch/pulse pair for 1..4 serial game pads and shifts
// their frames in parallel. Frames are started by poll_req or an optional
// free-running auto-poll tick. Every output is a flop.
`timescale 1ns/1ps
module serial_pad_scanner #(
  parameter int CHANNELS     = 1,
  parameter int BITS         = 8,
  parameter int LATCH_CYCLES = 12,
  parameter int DIV          = 6,
  parameter int POLL_PERIOD  = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     poll_req,
  output logic                     famicom_latch,
  output logic                     famicom_pulse,
  input  logic [CHANNELS-1:0]      famicom_data,
  output logic [CHANNELS*BITS-1:0] buttons,
  output logic                     valid,
  output logic                     changed,
  output logic                     busy
);
  localparam int PMAX = (LATCH_CYCLES > DIV) ? LATCH_CYCLES : DIV;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int BW   = $clog2(BITS);
  localparam int NB   = CHANNELS * BITS;
  localparam logic [PW-1:0] LATCH_LOAD = PW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] DIV_LOAD   = PW'(DIV - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETTLE, S_PULSE_HI, S_PULSE_LO, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                pending_q, pending_d;
  logic [NB-1:0]       cap_q, cap_d;
  logic [NB-1:0]       buttons_q, buttons_d;
  logic                valid_q, valid_d;
  logic                changed_q, changed_d;
  logic                latch_q, latch_d;
  logic                pulse_q, pulse_d;
  logic                busy_q, busy_d;
  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic                tick;
  logic                sample;
  logic                frame_done;
  logic [BW-1:0]       sample_bit;
  logic [BITS-1:0]     bit_sel;

  // Two-flop synchroniser per channel; idles at 1 so a missing pad reads released
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= famicom_data;
      sync2_q <= sync1_q;
    end
  end

  // Auto-poll: free-running 0..POLL_PERIOD-1 counter, tick on the wrap cycle
  generate
    if (POLL_PERIOD > 0) begin : g_poll
      localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
      localparam logic [TW-1:0] POLL_LAST = TW'(POLL_PERIOD - 1);
      logic [TW-1:0] cnt_q, cnt_d;

      assign tick = (cnt_q == POLL_LAST);

      // Next count value with wrap
      always_comb begin
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == POLL_LAST) cnt_d = '0;
      end

      // Counter register, runs regardless of frame activity
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end
    end else begin : g_no_poll
      assign tick = 1'b0;
    end
  endgenerate

  // Frame sequencer: next state, phase/bit counters, request merging, sample strobes
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    pending_d  = pending_q | poll_req | tick;
    sample     = 1'b0;
    sample_bit = bit_q;
    frame_done = 1'b0;
    if (state_q != S_IDLE && !enable) begin
      // Abort: drop the frame and any request queued behind it
      state_d   = S_IDLE;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable && pending_d) begin
            state_d   = S_LATCH;
            phase_d   = LATCH_LOAD;
            pending_d = 1'b0;
          end
        end
        S_LATCH: begin
          if (phase_q == '0) begin
            state_d = S_SETTLE;
            phase_d = DIV_LOAD;
          end else begin
            phase_d = phase_q - PW'(1);
          end
        end
        S_SETTLE: begin
          if (phase_q == '0) begin
            sample     = 1'b1;
            sample_bit = '0;
            state_d    = S_PULSE_HI;
            phase_d    = DIV_LOAD;
            bit_d      = BW'(1);
          end else begin
            phase_d = phase_q - PW'(1);
          end
        end
        S_PULSE_HI: begin
          if (phase_q == '0) begin
            state_d = S_PULSE_LO;
            phase_d = DIV_LOAD;
          end else begin
            phase_d = phase_q - PW'(1);
          end
        end
        S_PULSE_LO: begin
          if (phase_q == '0) begin
            sample = 1'b1;
            if (bit_q == LAST_BIT) begin
              state_d    = S_DONE;
              frame_done = 1'b1;
            end else begin
              state_d = S_PULSE_HI;
              phase_d = DIV_LOAD;
              bit_d   = bit_q + BW'(1);
            end
          end else begin
            phase_d = phase_q - PW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    // Line outputs are registered copies of the state being entered
    latch_d = (state_d == S_LATCH);
    pulse_d = (state_d == S_PULSE_HI);
    busy_d  = (state_d != S_IDLE);
  end

  // One-hot select of the bit being captured this cycle
  assign bit_sel = sample ? (BITS'(1) << sample_bit) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_cap
      assign cap_d[gi*BITS +: BITS] = (cap_q[gi*BITS +: BITS] & ~bit_sel) |
                                      ({BITS{sync2_q[gi]}} & bit_sel);
    end
  endgenerate

  // Publish the inverted capture at frame end and flag a difference from the last frame
  always_comb begin
    buttons_d = buttons_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    if (frame_done) begin
      buttons_d = ~cap_d;
      valid_d   = 1'b1;
      changed_d = (~cap_d != buttons_q);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      pending_q <= 1'b0;
      cap_q     <= '0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      pending_q <= pending_d;
      cap_q     <= cap_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      latch_q   <= latch_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
    end
  end

  assign famicom_latch = latch_q;
  assign famicom_pulse = pulse_q;
  assign buttons       = buttons_q;
  assign valid         = valid_q;
  assign changed       = changed_q;
  assign busy          = busy_q;

endmodule
